// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU (optional DIV_EARLY_OUT_EN)
module iterative_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            signed_div,
    input  logic            start,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero,
    output logic            valid,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    // dvd_q starts as |rs1| and is shifted out while quotient bits are shifted in
    logic [XLEN-1:0]  dvd_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  raw_rs1_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic             dz_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             calc_last;
    logic [XLEN-1:0]  rs1_mag;
    logic [XLEN-1:0]  rs2_mag;
    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    trial;

    assign accept    = (state == IDLE) && start;
    assign calc_last = (cnt_q == CNT_W'(XLEN - 1));

    // the most negative value negates to itself, which is its correct unsigned magnitude
    assign rs1_mag = (signed_div && rs1[XLEN-1]) ? (~rs1 + 1'b1) : rs1;
    assign rs2_mag = (signed_div && rs2[XLEN-1]) ? (~rs2 + 1'b1) : rs2;

    // partial remainder is always below the divisor, so one extra bit makes the borrow the sign
    assign rem_shift = {rem_q, dvd_q[XLEN-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_EARLY_OUT_EN
                    state_next = (rs2 == '0) ? FIX : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC:    state_next = calc_last ? FIX : CALC;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // operand capture and one restoring step per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            raw_rs1_q <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= '0;
        end else if (accept) begin
            dvd_q     <= rs1_mag;
            dvs_q     <= rs2_mag;
            rem_q     <= '0;
            raw_rs1_q <= rs1;
            sign_q_q  <= signed_div & (rs1[XLEN-1] ^ rs2[XLEN-1]);
            sign_r_q  <= signed_div & rs1[XLEN-1];
            dz_q      <= (rs2 == '0);
            cnt_q     <= '0;
        end else if (state == CALC) begin
            rem_q <= trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
            dvd_q <= {dvd_q[XLEN-2:0], ~trial[XLEN]};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // result registers, one-cycle valid strobe and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            valid       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (accept) begin
                busy <= 1'b1;
            end
            if (state == FIX) begin
                if (dz_q) begin
                    quotient  <= '1;
                    remainder <= raw_rs1_q;
                end else begin
                    quotient  <= sign_q_q ? (~dvd_q + 1'b1) : dvd_q;
                    remainder <= sign_r_q ? (~rem_q + 1'b1) : rem_q;
                end
                div_by_zero <= dz_q;
                valid       <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - scoreboard testbench for iterative_divider
module tb_iterative_divider;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;
`ifdef DIV_EARLY_OUT_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = XLEN + 2;
`endif

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            signed_div;
    logic            start;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            div_by_zero;
    logic            valid;
    logic            busy;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    iterative_divider #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1         (rs1),
        .rs2         (rs2),
        .signed_div  (signed_div),
        .start       (start),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .valid       (valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sd,
                         output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb_;
        sa  = a;
        sb_ = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sd && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sd) begin
            q = sa / sb_;
            r = sa % sb_;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // drives start at the current negedge, pushes the expectation, returns one negedge later
    task automatic drive_now(input logic [31:0] a, input logic [31:0] b, input logic sd,
                             input logic [31:0] eq, input logic [31:0] er, input logic edz);
        exp_t e;
        rs1        = a;
        rs2        = b;
        signed_div = sd;
        start      = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.cyc = cyc + (edz ? DZ_LAT : LAT);
        sb.push_back(e);
        @(negedge clk);
        start      = 1'b0;
        rs1        = $urandom;
        rs2        = $urandom;
        signed_div = $urandom_range(0, 1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sd,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
        @(negedge clk);
        drive_now(a, b, sd, eq, er, edz);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // scoreboard: every valid must match the oldest expectation, on the expected cycle
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                check("valid_cycle", cyc, e.cyc);
                check("busy_at_valid", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] a, b, eq, er;
        logic        sd;
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        rs1        = '0;
        rs2        = '0;
        signed_div = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_flags", {29'd0, div_by_zero, valid, busy}, 32'd0);
        rst_n = 1'b1;

        // unsigned 100/7 with busy window check
        @(negedge clk);
        drive_now(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        check("busy_first", {31'd0, busy}, 32'd1);
        repeat (32) @(negedge clk);
        check("busy_last", {31'd0, busy}, 32'd1);
        wait_idle();

        // signed cases
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        wait_idle();
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        wait_idle();

        // divide by zero
        do_op(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        wait_idle();

        // overflow and unsigned max
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        wait_idle();
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
        wait_idle();

        // start while busy is ignored
        @(negedge clk);
        drive_now(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (9) @(negedge clk);
        rs1   = 32'd50;
        rs2   = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // back-to-back: start in the valid cycle
        do_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);
        begin
            int n;
            n = 0;
            while (!valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("b2b_valid_seen", {31'd0, valid}, 32'd1);
        end
        drive_now(32'd55, 32'd6, 1'b0, 32'd9, 32'd1, 1'b0);
        wait_idle();

        // reset in the middle of an operation
        @(negedge clk);
        drive_now(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_flags", {29'd0, div_by_zero, valid, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        do_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);
        wait_idle();

        // random operands checked against the behavioural model
        for (int i = 0; i < 12; i++) begin
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'd0 : ((i % 4 == 1) ? $urandom_range(1, 20) : $urandom);
            if (i % 4 == 3 && b[31]) b = b >> $urandom_range(1, 31);
            sd = $urandom_range(0, 1);
            model(a, b, sd, eq, er);
            do_op(a, b, sd, eq, er, b == 32'd0);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
